// File: rtl/multiply_divide_sequencer_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: operation codes,
// sequencer states and ALU control codes, reused by hazard and decode logic.
package multiply_divide_sequencer_pkg;

    // Mul/div operation codes as presented on operation_input.
    // Bit 1 selects divide, bit 0 selects signed.
    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } md_op_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ITERATE = 2'b01,
        ST_ADJUST  = 2'b10,
        ST_DONE    = 2'b11
    } md_state_e;

    // Single-cycle ALU control codes, kept beside the mul/div codes so the
    // decoder pulls every EX-stage encoding from one place.
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_LUI  = 4'b1100;

    // True when the operation code selects a divide.
    function automatic logic op_is_div(input md_op_e op);
        return op[1];
    endfunction

    // True when the operation code selects a signed operation.
    function automatic logic op_is_signed(input md_op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/multiply_divide_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle,
// WIDTH steps per operation, followed by a sign-fixup cycle.
module multiply_divide_sequencer
    import multiply_divide_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_input,
    input  logic [1:0]       operation_input,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             cancel_input,
    input  logic             hi_write_input,
    input  logic             lo_write_input,
    input  logic [WIDTH-1:0] move_data_input,
    output logic             busy_output,
    output logic             done_output,
    output logic [WIDTH-1:0] hi_output,
    output logic [WIDTH-1:0] lo_output
);

    localparam int unsigned CW = $clog2(WIDTH);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             is_div_q, is_div_d;
    logic             sign_q, sign_d;          // product / quotient sign
    logic             rem_sign_q, rem_sign_d;  // remainder sign (dividend sign)
    logic [WIDTH-1:0] upper_q, upper_d;        // accumulator / partial remainder
    logic [WIDTH-1:0] lower_q, lower_d;        // multiplier / quotient
    logic [WIDTH-1:0] opnd_q, opnd_d;          // multiplicand / divisor magnitude
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Datapath intermediates
    md_op_e             op_in;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_diff;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_neg;
    logic [WIDTH-1:0]   quot_neg;
    logic [WIDTH-1:0]   rem_neg;

    // Next-state, datapath step and HI/LO update
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        is_div_d   = is_div_q;
        sign_d     = sign_q;
        rem_sign_d = rem_sign_q;
        upper_d    = upper_q;
        lower_d    = lower_q;
        opnd_d     = opnd_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        op_in = md_op_e'(operation_input);
        a_neg = op_is_signed(op_in) & operand_a[WIDTH-1];
        b_neg = op_is_signed(op_in) & operand_b[WIDTH-1];
        a_mag = a_neg ? (~operand_a + WIDTH'(1)) : operand_a;
        b_mag = b_neg ? (~operand_b + WIDTH'(1)) : operand_b;

        // Multiply step: conditional 33-bit add into the upper accumulator
        mul_sum = {1'b0, upper_q} + (lower_q[0] ? {1'b0, opnd_q} : '0);

        // Divide step: the 33-bit trial subtract is split into a compare and a
        // WIDTH-bit difference; when the trial succeeds the result is below the
        // divisor, so the dropped top bit is always zero.
        rem_shift = {upper_q, lower_q[WIDTH-1]};
        rem_ge    = rem_shift[WIDTH] | (rem_shift[WIDTH-1:0] >= opnd_q);
        rem_diff  = rem_shift[WIDTH-1:0] - opnd_q;

        product     = {upper_q, lower_q};
        product_neg = ~product + (2*WIDTH)'(1);
        quot_neg    = ~lower_q + WIDTH'(1);
        rem_neg     = ~upper_q + WIDTH'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (hi_write_input) hi_d = move_data_input;
                if (lo_write_input) lo_d = move_data_input;
                if (start_input) begin
                    count_d  = '0;
                    is_div_d = op_is_div(op_in);
                    sign_d   = a_neg ^ b_neg;
                    upper_d  = '0;
                    state_d  = ST_ITERATE;
                    if (op_is_div(op_in)) begin
                        rem_sign_d = a_neg;
                        opnd_d     = b_mag;
                        lower_d    = a_mag;
                        // Divide by zero: preload the final HI/LO values with
                        // no sign fixup and let ADJUST write them next edge.
                        if (operand_b == '0) begin
                            upper_d    = operand_a;
                            lower_d    = '1;
                            sign_d     = 1'b0;
                            rem_sign_d = 1'b0;
                            state_d    = ST_ADJUST;
                        end
                    end else begin
                        rem_sign_d = 1'b0;
                        opnd_d     = a_mag;
                        lower_d    = b_mag;
                    end
                end
            end
            ST_ITERATE: begin
                if (cancel_input) begin
                    state_d = ST_IDLE;
                end else begin
                    if (is_div_q) begin
                        upper_d = rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
                        lower_d = {lower_q[WIDTH-2:0], rem_ge};
                    end else begin
                        upper_d = mul_sum[WIDTH:1];
                        lower_d = {mul_sum[0], lower_q[WIDTH-1:1]};
                    end
                    count_d = count_q + CW'(1);
                    if (count_q == '1) state_d = ST_ADJUST;
                end
            end
            ST_ADJUST: begin
                if (cancel_input) begin
                    state_d = ST_IDLE;
                end else begin
                    if (is_div_q) begin
                        hi_d = rem_sign_q ? rem_neg  : upper_q;
                        lo_d = sign_q     ? quot_neg : lower_q;
                    end else begin
                        {hi_d, lo_d} = sign_q ? product_neg : product;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State register with synchronous reset; status outputs are registered
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            is_div_q   <= 1'b0;
            sign_q     <= 1'b0;
            rem_sign_q <= 1'b0;
            upper_q    <= '0;
            lower_q    <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            is_div_q   <= is_div_d;
            sign_q     <= sign_d;
            rem_sign_q <= rem_sign_d;
            upper_q    <= upper_d;
            lower_q    <= lower_d;
            opnd_q     <= opnd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy_output = busy_q;
    assign done_output = done_q;
    assign hi_output   = hi_q;
    assign lo_output   = lo_q;

endmodule

// File: tb/tb_multiply_divide_sequencer.sv
// Directed bench for multiply_divide_sequencer: hand-computed products,
// quotients, latency, move, cancel and reset scenarios.
module tb_multiply_divide_sequencer;

    localparam int unsigned W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cancel = 1'b0;
    logic         hi_wr = 1'b0;
    logic         lo_wr = 1'b0;
    logic [W-1:0] move = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int vectors = 0;
    int miscompares = 0;

    multiply_divide_sequencer #(.WIDTH(W)) dut (
        .clock           (clock),
        .reset           (reset),
        .start_input     (start),
        .operation_input (op),
        .operand_a       (a),
        .operand_b       (b),
        .cancel_input    (cancel),
        .hi_write_input  (hi_wr),
        .lo_write_input  (lo_wr),
        .move_data_input (move),
        .busy_output     (busy),
        .done_output     (done),
        .hi_output       (hi),
        .lo_output       (lo)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick;
        start = 1'b0;
    endtask

    // Sample once per cycle until busy drops (bounded); the first sample is
    // the cycle right after the caller's last edge.
    task automatic wait_done(output int lat, output int busy_cyc, output int done_cyc,
                             output logic [W-1:0] hi_at, output logic [W-1:0] lo_at);
        lat = -1;
        busy_cyc = 0;
        done_cyc = 0;
        hi_at = 'x;
        lo_at = 'x;
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            busy_cyc++;
            if (done) begin
                if (lat < 0) lat = i;
                done_cyc++;
                hi_at = hi;
                lo_at = lo;
            end
            tick;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, input int exp_lat);
        int lat, bc, dc;
        logic [W-1:0] h, l;
        accept(o, x, y);
        wait_done(lat, bc, dc, h, l);
        chk({tag, "_hi"}, h, exp_hi);
        chk({tag, "_lo"}, l, exp_lo);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy"}, bc, exp_lat + 1);
        chk({tag, "_done1"}, dc, 1);
    endtask

    initial begin : stim
        int lat, bc, dc, seen;
        logic [W-1:0] h, l;

        // Reset state
        tick;
        tick;
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);

        // MTLO in IDLE
        lo_wr = 1'b1; move = 32'h0000_1234;
        tick;
        lo_wr = 1'b0;
        chk("mtlo_lo", lo, 32'h0000_1234);
        chk("mtlo_hi", hi, 0);

        // MTHI and MTLO together
        hi_wr = 1'b1; lo_wr = 1'b1; move = 32'h0000_0055;
        tick;
        hi_wr = 1'b0; lo_wr = 1'b0;
        chk("mtboth_hi", hi, 32'h55);
        chk("mtboth_lo", lo, 32'h55);

        // Arithmetic
        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
        run_op("mult_m3x7", 2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
        run_op("mult_min2", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_op("div_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
        run_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
        run_op("divu_5_0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1);
        run_op("div_m5_0", 2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1);

        // Start together with MTLO: move lands at accept, result overwrites later
        lo_wr = 1'b1; move = 32'h0000_0777;
        accept(2'b00, 32'd2, 32'd3);
        lo_wr = 1'b0;
        chk("stmv_lo_early", lo, 32'h777);
        chk("stmv_busy", busy, 1);
        wait_done(lat, bc, dc, h, l);
        chk("stmv_hi", h, 0);
        chk("stmv_lo", l, 6);
        chk("stmv_lat", lat, 33);

        // Start and MTHI while busy are ignored
        accept(2'b00, 32'd3, 32'd4);
        for (int i = 0; i < 5; i++) tick;
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        hi_wr = 1'b1; move = 32'h0000_DEAD;
        tick;
        start = 1'b0; hi_wr = 1'b0;
        wait_done(lat, bc, dc, h, l);
        chk("busyign_hi", h, 0);
        chk("busyign_lo", l, 12);
        chk("busyign_lat", lat, 27);
        chk("busyign_hi_after", hi, 0);
        chk("busyign_idle", busy, 0);

        // Cancel at iteration 10
        hi_wr = 1'b1; move = 32'h0000_000A;
        tick;
        hi_wr = 1'b0; lo_wr = 1'b1; move = 32'h0000_000B;
        tick;
        lo_wr = 1'b0;
        accept(2'b00, 32'hFFFF_FFFF, 32'd2);
        for (int i = 0; i < 9; i++) tick;
        cancel = 1'b1;
        tick;
        cancel = 1'b0;
        chk("cancel_busy", busy, 0);
        chk("cancel_done", done, 0);
        chk("cancel_hi", hi, 32'hA);
        chk("cancel_lo", lo, 32'hB);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            tick;
        end
        chk("cancel_nodone", seen, 0);
        chk("cancel_hi_hold", hi, 32'hA);

        // Cancel together with start in IDLE: start wins
        cancel = 1'b1;
        accept(2'b00, 32'd5, 32'd5);
        cancel = 1'b0;
        chk("cstart_busy", busy, 1);
        wait_done(lat, bc, dc, h, l);
        chk("cstart_lo", l, 25);
        chk("cstart_lat", lat, 33);

        // Cancel in DONE: the write stands
        accept(2'b10, 32'd9, 32'd2);
        for (int i = 0; i < 40 && !done; i++) tick;
        chk("cdone_seen", done, 1);
        cancel = 1'b1;
        tick;
        cancel = 1'b0;
        chk("cdone_busy", busy, 0);
        chk("cdone_hi", hi, 1);
        chk("cdone_lo", lo, 4);

        // Reset at iteration 10
        accept(2'b01, 32'd7, 32'hFFFF_FFFF);
        for (int i = 0; i < 9; i++) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_hi", hi, 0);
        chk("rstmid_lo", lo, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            tick;
        end
        chk("rstmid_nodone", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
